sound_ctrl: RTL and testbench

Sound-port controller for the BattleZone audio path. It decodes CPU writes to the sound control latch and drives the enable inputs of the engine, shell and explosion generators, including one-shot triggers. It sums the generator outputs with saturation and applies a click-free master-gain ramp driven by a four-state mute state machine. It sits between the CPU bus decode and the DAC output stage, and all audio activity is paced by `clk_3MHz_en`.

---
 rtl/sound_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sound_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_ctrl.sv
// sound_ctrl: BattleZone sound-port controller.
// Decodes the CPU sound latch into generator enables and one-shot triggers,
// mixes the three voices with saturation and applies a click-free master
// gain driven by a four-state mute machine. All audio work advances on
// clk_3MHz_en ticks.
// Optional feature macro: SOUND_CTRL_RAMP_EN (gradual ramp with RAMP_DIV
// ticks per gain step). Undefined: gain jumps 0 <-> 256 in one tick.
module sound_ctrl #(
    parameter int RAMP_DIV = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_3MHz_en,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_data,
    input  logic [15:0] engine_in,
    input  logic [15:0] shell_in,
    input  logic [15:0] expl_in,
    output logic        motor_en,
    output logic        engine_rev_en,
    output logic        shell_trig,
    output logic        expl_trig,
    output logic        shell_loud,
    output logic        expl_loud,
    output logic [15:0] out,
    output logic [1:0]  state,
    output logic        busy
);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [8:0] GAIN_MAX = 9'd256;

`ifdef SOUND_CTRL_RAMP_EN
    localparam logic [8:0] STEP     = 9'd1;
    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);
`else
    localparam logic [8:0] STEP     = 9'd256;
`endif

    // Reject divider values the 8-bit counter cannot represent.
    if (RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_ramp_div
        $error("sound_ctrl: RAMP_DIV must be in 1..255");
    end

    // Clamp a three-voice sum into the 16-bit sample range.
    function automatic logic [15:0] sat_sum(input logic [17:0] s);
        return (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    endfunction

    // Scale a sample by gain/256; gain 256 is unity.
    function automatic logic [15:0] apply_gain(input logic [15:0] x, input logic [8:0] g);
        logic [24:0] p;
        p = {9'd0, x} * {16'd0, g};
        return p[23:8];
    endfunction

    // Gain increment that stops at unity instead of wrapping.
    function automatic logic [8:0] gain_up(input logic [8:0] g);
        logic [9:0] t;
        t = {1'b0, g} + {1'b0, STEP};
        return (t > {1'b0, GAIN_MAX}) ? GAIN_MAX : t[8:0];
    endfunction

    // Gain decrement that stops at zero instead of wrapping.
    function automatic logic [8:0] gain_down(input logic [8:0] g);
        return (g > STEP) ? (g - STEP) : 9'd0;
    endfunction

    logic [7:0] latch;
    logic [7:0] latch_n;
    logic       shell_pend;
    logic       expl_pend;
    logic       shell_rise;
    logic       expl_rise;

    assign latch_n    = cpu_wr ? cpu_data : latch;
    assign shell_rise = cpu_wr & cpu_data[2] & ~latch[2];
    assign expl_rise  = cpu_wr & cpu_data[0] & ~latch[0];

    // Sound latch and level outputs, decoded from the incoming write so they
    // appear one clk after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch         <= 8'd0;
            motor_en      <= 1'b0;
            engine_rev_en <= 1'b0;
            shell_loud    <= 1'b0;
            expl_loud     <= 1'b0;
        end else begin
            latch         <= latch_n;
            motor_en      <= latch_n[7] & latch_n[5];
            engine_rev_en <= latch_n[4] & latch_n[5];
            shell_loud    <= latch_n[3];
            expl_loud     <= latch_n[1];
        end
    end

    // Pending one-shot flags: set on a rising latch bit, consumed by the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            shell_pend <= 1'b0;
            expl_pend  <= 1'b0;
        end else begin
            shell_pend <= (shell_pend & ~clk_3MHz_en) | shell_rise;
            expl_pend  <= (expl_pend & ~clk_3MHz_en) | expl_rise;
        end
    end

    // Triggers coincide with the tick; reset suppresses an edge still pending.
    assign shell_trig = shell_pend & clk_3MHz_en & ~rst;
    assign expl_trig  = expl_pend & clk_3MHz_en & ~rst;

    state_t     state_q;
    state_t     state_n;
    logic [8:0] gain_q;
    logic [8:0] gain_n;
    logic       step_now;
`ifdef SOUND_CTRL_RAMP_EN
    logic [7:0] div_q;
    logic [7:0] div_n;
`endif

    // Mute state machine next-state and gain; only ticks move it.
    always_comb begin
        state_n = state_q;
        gain_n  = gain_q;
`ifdef SOUND_CTRL_RAMP_EN
        div_n    = div_q;
        step_now = (div_q == DIV_LAST);
`else
        step_now = 1'b1;
`endif
        if (clk_3MHz_en) begin
            case (state_q)
                MUTED: begin
                    gain_n = 9'd0;
                    if (latch[5]) state_n = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!latch[5]) begin
                        state_n = RAMP_DOWN;
                    end else if (step_now) begin
                        gain_n = gain_up(gain_q);
                        if (gain_n == GAIN_MAX) state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    gain_n = GAIN_MAX;
                    if (!latch[5]) state_n = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (latch[5]) begin
                        state_n = RAMP_UP;
                    end else if (step_now) begin
                        gain_n = gain_down(gain_q);
                        if (gain_n == 9'd0) state_n = MUTED;
                    end
                end
                default: begin
                    state_n = MUTED;
                    gain_n  = 9'd0;
                end
            endcase
`ifdef SOUND_CTRL_RAMP_EN
            // Every state change restarts the step divider.
            if (state_n != state_q)
                div_n = 8'd0;
            else if (state_q == RAMP_UP || state_q == RAMP_DOWN)
                div_n = step_now ? 8'd0 : 8'(div_q + 8'd1);
            else
                div_n = 8'd0;
`endif
        end
    end

    // Mute state machine register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTED;
            gain_q  <= 9'd0;
`ifdef SOUND_CTRL_RAMP_EN
            div_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_n;
            gain_q  <= gain_n;
`ifdef SOUND_CTRL_RAMP_EN
            div_q   <= div_n;
`endif
        end
    end

    assign state = state_q;
    assign busy  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

    // ---- stage p0: raw three-voice sum ----
    logic [17:0] sum_p0;
    assign sum_p0 = {2'b00, engine_in} + {2'b00, shell_in} + {2'b00, expl_in};

    // ---- stage p1: saturated sum ----
    logic [15:0] sat_p1;
    logic        vld_p1;

    // Saturated-sum register, advanced on ticks.
    always_ff @(posedge clk) begin
        if (clk_3MHz_en) sat_p1 <= sat_sum(sum_p0);
    end

    // Marks that sat_p1 holds a sampled value since reset.
    always_ff @(posedge clk) begin
        if (rst)              vld_p1 <= 1'b0;
        else if (clk_3MHz_en) vld_p1 <= 1'b1;
    end

    // ---- stage p2: gained output ----
    logic [15:0] out_p2;

    // Output register: apply master gain on ticks, hold between them.
    always_ff @(posedge clk) begin
        if (rst)              out_p2 <= 16'd0;
        else if (clk_3MHz_en) out_p2 <= vld_p1 ? apply_gain(sat_p1, gain_q) : 16'd0;
    end

    assign out = out_p2;

endmodule

// File: tb/tb_sound_ctrl.sv
// Self-checking bench for sound_ctrl (instantiated with RAMP_DIV=2).
// Default build checks the one-tick ramp; with SOUND_CTRL_RAMP_EN defined
// the gradual ramp and reversal sequences are checked instead.
module tb_sound_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tk = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  d = 8'd0;
    logic [15:0] e = 16'd0;
    logic [15:0] s = 16'd0;
    logic [15:0] x = 16'd0;
    logic        motor_en, engine_rev_en, shell_trig, expl_trig, shell_loud, expl_loud;
    logic [15:0] out;
    logic [1:0]  state;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sound_ctrl #(.RAMP_DIV(2)) dut (
        .clk(clk), .rst(rst), .clk_3MHz_en(tk), .cpu_wr(wr), .cpu_data(d),
        .engine_in(e), .shell_in(s), .expl_in(x),
        .motor_en(motor_en), .engine_rev_en(engine_rev_en),
        .shell_trig(shell_trig), .expl_trig(expl_trig),
        .shell_loud(shell_loud), .expl_loud(expl_loud),
        .out(out), .state(state), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Set inputs on the falling edge; combinational outputs settle 1 later.
    task automatic drive(input logic t, input logic w, input logic [7:0] dd);
        @(negedge clk);
        tk = t; wr = w; d = dd;
        #1;
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tk = 1'b1; wr = 1'b0;
        #1;
        post();
        @(negedge clk);
        rst = 1'b0; tk = 1'b0;
    endtask

    typedef struct {
        logic        t, w;
        logic [7:0]  dd;
        logic [15:0] ee, ss, xx;
        logic [5:0]  lv;   // motor, rev, shell_loud, expl_loud, shell_trig, expl_trig
        logic [1:0]  st;
        logic        cs;
        logic [15:0] oo;
        logic        co;
    } vec_t;

    function automatic vec_t mk(logic t, logic w, logic [7:0] dd, logic [15:0] ee,
                                logic [15:0] ss, logic [15:0] xx, logic [5:0] lv,
                                logic [1:0] st, logic cs, logic [15:0] oo, logic co);
        vec_t v;
        v.t = t; v.w = w; v.dd = dd; v.ee = ee; v.ss = ss; v.xx = xx;
        v.lv = lv; v.st = st; v.cs = cs; v.oo = oo; v.co = co;
        return v;
    endfunction

`ifndef SOUND_CTRL_RAMP_EN
    vec_t tv[31];
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] peak;

        // Reset state
        rst = 1'b1; tk = 1'b1;
        post(); post();
        chk("rst motor", motor_en, 0);
        chk("rst rev", engine_rev_en, 0);
        chk("rst sloud", shell_loud, 0);
        chk("rst eloud", expl_loud, 0);
        chk("rst strig", shell_trig, 0);
        chk("rst etrig", expl_trig, 0);
        chk("rst out", out, 0);
        chk("rst state", state, 0);
        chk("rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; tk = 1'b0;
        e = 16'h0100; s = 16'h0; x = 16'h0;

`ifndef SOUND_CTRL_RAMP_EN
        tv[0]  = mk(1,0,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 0,1, 16'h0000,1);
        tv[1]  = mk(0,1,8'hA0, 16'h0100,16'h0,16'h0, 6'b100000, 0,1, 16'h0000,1);
        tv[2]  = mk(1,0,8'hA0, 16'h0100,16'h0,16'h0, 6'b100000, 1,1, 16'h0000,1);
        tv[3]  = mk(1,0,8'hA0, 16'h0100,16'h0,16'h0, 6'b100000, 2,1, 16'h0000,1);
        tv[4]  = mk(1,0,8'hA0, 16'h0100,16'h0,16'h0, 6'b100000, 2,1, 16'h0100,1);
        tv[5]  = mk(0,1,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0100,1);
        tv[6]  = mk(1,0,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 3,1, 16'h0100,1);
        tv[7]  = mk(1,0,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 0,1, 16'h0000,0);
        tv[8]  = mk(1,0,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 0,1, 16'h0000,0);
        tv[9]  = mk(1,0,8'h00, 16'h0100,16'h0,16'h0, 6'b000000, 0,1, 16'h0000,1);
        tv[10] = mk(0,1,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 0,1, 16'h0000,1);
        tv[11] = mk(1,0,8'h21, 16'h0100,16'h0,16'h0, 6'b000001, 1,1, 16'h0000,1);
        tv[12] = mk(0,1,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 1,1, 16'h0000,1);
        tv[13] = mk(1,0,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0000,0);
        tv[14] = mk(0,1,8'h20, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0000,0);
        tv[15] = mk(1,0,8'h20, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0100,1);
        tv[16] = mk(0,1,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0100,1);
        tv[17] = mk(0,0,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0100,1);
        tv[18] = mk(1,0,8'h21, 16'h0100,16'h0,16'h0, 6'b000001, 2,1, 16'h0100,1);
        tv[19] = mk(1,0,8'h21, 16'h0100,16'h0,16'h0, 6'b000000, 2,1, 16'h0100,1);
        tv[20] = mk(0,1,8'h9A, 16'h0100,16'h0,16'h0, 6'b001100, 2,1, 16'h0100,1);
        tv[21] = mk(1,0,8'h9A, 16'h0100,16'h0,16'h0, 6'b001100, 3,1, 16'h0000,0);
        tv[22] = mk(0,1,8'hBC, 16'h0100,16'h0,16'h0, 6'b111000, 3,1, 16'h0000,0);
        tv[23] = mk(1,0,8'hBC, 16'h0100,16'h0,16'h0, 6'b111010, 1,1, 16'h0000,0);
        tv[24] = mk(1,0,8'hBC, 16'h0100,16'h0,16'h0, 6'b111000, 2,1, 16'h0000,0);
        tv[25] = mk(1,0,8'hBC, 16'h8000,16'h8000,16'h0001, 6'b111000, 2,1, 16'h0000,0);
        tv[26] = mk(1,0,8'hBC, 16'h1000,16'h1000,16'h1000, 6'b111000, 2,1, 16'hFFFF,1);
        tv[27] = mk(1,0,8'hBC, 16'h1000,16'h1000,16'h1000, 6'b111000, 2,1, 16'h3000,1);
        tv[28] = mk(0,0,8'hBC, 16'hFFFF,16'hFFFF,16'hFFFF, 6'b111000, 2,1, 16'h3000,1);
        tv[29] = mk(1,0,8'hBC, 16'hFFFF,16'hFFFF,16'hFFFF, 6'b111000, 2,1, 16'h3000,1);
        tv[30] = mk(1,0,8'hBC, 16'hFFFF,16'hFFFF,16'hFFFF, 6'b111000, 2,1, 16'hFFFF,1);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            tk = tv[i].t; wr = tv[i].w; d = tv[i].dd;
            e = tv[i].ee; s = tv[i].ss; x = tv[i].xx;
            #1;
            chk($sformatf("v%0d shell_trig", i), shell_trig, tv[i].lv[1]);
            chk($sformatf("v%0d expl_trig", i), expl_trig, tv[i].lv[0]);
            post();
            chk($sformatf("v%0d motor_en", i), motor_en, tv[i].lv[5]);
            chk($sformatf("v%0d engine_rev_en", i), engine_rev_en, tv[i].lv[4]);
            chk($sformatf("v%0d shell_loud", i), shell_loud, tv[i].lv[3]);
            chk($sformatf("v%0d expl_loud", i), expl_loud, tv[i].lv[2]);
            if (tv[i].cs) begin
                chk($sformatf("v%0d state", i), state, tv[i].st);
                chk($sformatf("v%0d busy", i), busy, (tv[i].st == 2'd1 || tv[i].st == 2'd3));
            end
            if (tv[i].co) chk($sformatf("v%0d out", i), out, tv[i].oo);
        end
        e = 16'h0100; s = 16'h0; x = 16'h0;
`else
        // Full ramp with RAMP_DIV=2: 512 ticks in RAMP_UP
        do_reset();
        drive(0, 1, 8'hA0); post();
        chk("ramp motor", motor_en, 1);
        chk("ramp state pre", state, 0);
        drive(1, 0, 8'hA0); post();
        chk("ramp state up", state, 1);
        chk("ramp busy up", busy, 1);
        n = 0;
        while (state == 2'd1 && n < 2000) begin
            drive(1, 0, 8'hA0); post();
            n++;
        end
        chk("ramp up ticks", n, 512);
        chk("ramp state active", state, 2);
        chk("ramp busy active", busy, 0);
        drive(1, 0, 8'hA0); post();
        chk("ramp unity out", out, 16'h0100);

        // Reversal at gain 100
        do_reset();
        drive(0, 1, 8'h20); post();
        drive(1, 0, 8'h20); post();
        chk("rev state up", state, 1);
        for (int i = 0; i < 200; i++) begin
            drive(1, 0, 8'h20); post();
        end
        drive(0, 1, 8'h00); post();
        chk("rev motor", motor_en, 0);
        drive(1, 0, 8'h00); post();
        chk("rev state down", state, 3);
        chk("rev out start", out, 16'd100);
        peak = out;
        n = 0;
        while (state == 2'd3 && n < 1000) begin
            drive(1, 0, 8'h00); post();
            if (out > peak) peak = out;
            n++;
        end
        chk("rev down ticks", n, 200);
        chk("rev peak", peak, 16'd100);
        chk("rev state muted", state, 0);
        drive(1, 0, 8'h00); post();
        drive(1, 0, 8'h00); post();
        chk("rev out zero", out, 0);
`endif

        // 1->0->1 before a tick gives one expl pulse
        do_reset();
        drive(0, 1, 8'h01); post();
        drive(0, 1, 8'h00); post();
        drive(0, 1, 8'h01);
        chk("rtr notick", expl_trig, 0);
        post();
        drive(1, 0, 8'h01);
        chk("rtr pulse", expl_trig, 1);
        post();
        drive(1, 0, 8'h01);
        chk("rtr single", expl_trig, 0);
        post();

        // Reset during RAMP_DOWN with a shell edge pending
        do_reset();
        drive(0, 1, 8'h20); post();
        drive(1, 0, 8'h20); post();
        chk("mrst state up", state, 1);
        drive(0, 1, 8'h00); post();
        drive(1, 0, 8'h00); post();
        chk("mrst state down", state, 3);
        drive(0, 1, 8'h04); post();
        chk("mrst sloud pre", shell_loud, 0);
        @(negedge clk);
        rst = 1'b1; tk = 1'b1; wr = 1'b0;
        #1;
        chk("mrst trig in rst", shell_trig, 0);
        post();
        chk("mrst state", state, 0);
        chk("mrst out", out, 0);
        chk("mrst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h00);
            chk($sformatf("mrst no trig %0d", i), shell_trig, 0);
            post();
            chk($sformatf("mrst muted %0d", i), state, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
